// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction-fetch front end. Presents fetch_pc to an asynchronous-read
//   instruction memory, captures the returned word whenever the queue has
//   room, and buffers {pc, instruction} pairs for decode behind a
//   valid/ready handshake. A redirect flushes the queue and restarts fetch.
//   After an ecall is fetched, fetching stops until the next redirect.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   imem_addr       byte address to instruction memory (= fetch_pc)
//   imem_dout       instruction word at imem_addr, same cycle
//   redirect_valid  flush queue and restart fetch at redirect_pc
//   redirect_pc     new fetch address, low two bits forced to 0
//   out_valid       queue head valid
//   out_ready       decode accepts the head this cycle
//   out_inst        head instruction (0 when empty)
//   out_pc          head PC (0 when empty)
//   count           queue occupancy, 0..DEPTH
//   halted          fetch stopped after an ecall
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_dout,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fsm_t;

    fsm_t             state;
    fsm_t             state_next;
    logic [31:0]      fetch_pc;
    logic [63:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic [63:0]      head;
    logic             pop;
    logic             push;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full queue still accepts a new word when the head leaves the same cycle.
    assign push      = (state == RUN) & ~redirect_valid
                     & ((count_q < CNT_W'(DEPTH)) | pop);

    // Control state: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset; empty entries are never visible because the
    // outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr] <= {fetch_pc, imem_dout};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // The ecall itself is queued; halting takes effect at the same edge.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = RUN;
        end else if (state == RUN && push && imem_dout == ECALL) begin
            state_next = HALTED;
        end
    end

    assign head      = fifo_mem[rd_ptr];
    assign out_pc    = out_valid ? head[63:32] : 32'd0;
    assign out_inst  = out_valid ? head[31:0]  : 32'd0;
    assign imem_addr = fetch_pc;
    assign count     = count_q;
    assign halted    = (state == HALTED);

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction-fetch front end of the pipelined core. Drives the address of the asynchronous-read instruction memory, captures the returned word every cycle that queue space exists, and buffers {pc, instruction} pairs in a small FIFO for the decode stage through a valid/ready handshake. Supports redirect (branch/jump flush) from later stages and stops fetching after an `ecall` until redirected.

## Interface
- DEPTH, 4: queue entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- imem_addr  out  32  byte address to instruction memory; equals fetch_pc.
- imem_dout  in  32  instruction word at imem_addr, valid combinationally in the same cycle.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and stored as 0.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  head instruction; 0 when out_valid=0.
- out_pc  out  32  head PC; 0 when out_valid=0.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- halted  out  1  fetch stopped after `ecall`.

## Operation
- State: fetch_pc (32b), FIFO storage (DEPTH × 64b), rd_ptr/wr_ptr (mod DEPTH), count, fsm ∈ {RUN, HALTED}.
- pop = out_valid & out_ready.
- push = (fsm==RUN) & !redirect_valid & (count<DEPTH | pop).
- On push: write {fetch_pc, imem_dout} at wr_ptr; wr_ptr+1; fetch_pc ← fetch_pc+4 (mod 2^32, wraps silently).
- On pop: rd_ptr+1.
- count next = count + push − pop; full with pop in the same cycle → push allowed, count unchanged.
- Pushed word == 32'h0000_0073 (`ecall`): fsm RUN→HALTED at the same edge; the ecall itself is queued; fetch_pc = ecall PC+4 and holds.
- HALTED: no pushes; pops continue; queue drains normally.
- redirect_valid (highest priority, any state): count←0, rd_ptr←wr_ptr←0, fetch_pc←{redirect_pc[31:2],2'b00}, fsm←RUN; a simultaneous pop or push is discarded.
- out_valid = (count≠0); out_inst/out_pc = head entry, gated to 0 when empty.
- halted = (fsm==HALTED).

## Timing
- Reset values (while reset=1 and first cycle after): fetch_pc=RESET_PC, imem_addr=RESET_PC, count=0, out_valid=0, out_inst=0, out_pc=0, halted=0, pointers 0, fsm=RUN. imem_dout is ignored while reset=1 (memory is being reinitialized).
- Reset has priority over redirect; reset mid-stream discards all entries.
- First push at the first rising edge with reset=0; out_valid=1 one cycle later with out_pc=RESET_PC.
- Fetch-to-output latency: 1 cycle (entry pushed at edge t visible at head after t if queue was empty).
- Throughput: 1 instruction/cycle sustained with out_ready=1.
- Redirect asserted in cycle t: cycle t+1 imem_addr=redirect_pc, out_valid=0, count=0; cycle t+2 out_valid=1, out_pc=redirect_pc.
- out_inst/out_pc stable while out_valid=1 and out_ready=0 (no redirect).
- No combinational path from out_ready or redirect_valid to imem_addr; out_valid depends only on registers.

## Test plan
- Fill: mem words 0x00100093, 0x00200113, 0x00300193, 0x00400213, 0x00500293; out_ready=0 → after 4 cycles count=4, imem_addr=0x10 held, out_pc=0x0, out_inst=0x00100093.
- Stream: same program, out_ready=1 → out_pc 0x0,0x4,0x8,... one per cycle from the second cycle after reset; count stays 1.
- Full + pop: queue full, out_ready pulsed one cycle → count stays 4, imem_addr advances 0x10→0x14, new head out_pc=0x4.
- Redirect: queue full, out_ready=1, redirect_valid=1 with redirect_pc=0x43 → next cycle count=0, out_valid=0, imem_addr=0x40; following cycle out_pc=0x40.
- Halt: 0x00000073 at 0x8, out_ready=0 → entries 0x0,0x4,0x8 queued, count=3, halted=1, imem_addr=0xC held; drain → count=0, out_valid=0; redirect to 0x0 → halted=0, fetch resumes at 0x0.
- Reset mid-stream: reset=1 for one cycle with count=2 → count=0, out_valid=0, out_inst=0, imem_addr=RESET_PC, halted=0.
